// File: rtl/conv_window_scheduler_if.sv
// Handshake bundle between the window scheduler, the patch latch and the MAC.
// The scheduler takes the master side; the environment takes the slave side.
interface conv_window_scheduler_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              load;
    logic              load_full_patch;
    logic              load_done;
    logic [ADDR_W-1:0] pixel_addr0;
    logic [ADDR_W-1:0] pixel_addr1;
    logic [ADDR_W-1:0] pixel_addr2;
    logic [ADDR_W-1:0] pixel_addr3;
    logic [ADDR_W-1:0] pixel_addr4;
    logic [ADDR_W-1:0] pixel_addr5;
    logic [ADDR_W-1:0] pixel_addr6;
    logic [ADDR_W-1:0] pixel_addr7;
    logic [ADDR_W-1:0] pixel_addr8;
    logic              patch_valid;
    logic              patch_ready;
    logic [ADDR_W-1:0] out_row;
    logic [ADDR_W-1:0] out_col;
    logic              busy;
    logic              scan_done;

    modport master (
        input  start, load_done, patch_ready,
        output load, load_full_patch,
        output pixel_addr0, pixel_addr1, pixel_addr2,
        output pixel_addr3, pixel_addr4, pixel_addr5,
        output pixel_addr6, pixel_addr7, pixel_addr8,
        output patch_valid, out_row, out_col, busy, scan_done
    );

    modport slave (
        output start, load_done, patch_ready,
        input  load, load_full_patch,
        input  pixel_addr0, pixel_addr1, pixel_addr2,
        input  pixel_addr3, pixel_addr4, pixel_addr5,
        input  pixel_addr6, pixel_addr7, pixel_addr8,
        input  patch_valid, out_row, out_col, busy, scan_done
    );
endinterface

// File: rtl/conv_window_scheduler.sv
// 3x3 window scheduler: walks the image column-major, drives latch loads
// and presents each patch to the MAC with a valid/ready handshake.
module conv_window_scheduler #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    conv_window_scheduler_if.master  bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] PRESENT = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] W1       = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] W2       = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 3);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mask;

    // State, counters and top-left base address; base tracks row*IMG_W+col.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
        end
    end

    // Next state: row step adds IMG_W to base, column step reloads it to col.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                row_d  = '0;
                col_d  = '0;
                base_d = '0;
                if (bus.start) state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.load_done) state_d = PRESENT;
            end
            PRESENT: begin
                if (bus.patch_ready) begin
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            base_d  = '0;
                            state_d = FINISH;
                        end else begin
                            col_d   = col_q + ONE;
                            base_d  = col_q + ONE;
                            state_d = ISSUE;
                        end
                    end else begin
                        row_d   = row_q + ONE;
                        base_d  = base_q + W1;
                        state_d = ISSUE;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.load            = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.load_full_patch = bus.load && (row_q == '0);
    assign bus.patch_valid     = (state_q == PRESENT);
    assign bus.busy            = (state_q == ISSUE) || (state_q == WAIT)
                               || (state_q == PRESENT);
    assign bus.scan_done       = (state_q == FINISH);
    assign bus.out_row         = row_q;
    assign bus.out_col         = col_q;

    // Addresses read as zero whenever no scan is active.
    assign mask = {ADDR_W{bus.busy}};

    assign bus.pixel_addr0 = base_q & mask;
    assign bus.pixel_addr1 = (base_q + ONE) & mask;
    assign bus.pixel_addr2 = (base_q + TWO) & mask;
    assign bus.pixel_addr3 = (base_q + W1) & mask;
    assign bus.pixel_addr4 = (base_q + W1 + ONE) & mask;
    assign bus.pixel_addr5 = (base_q + W1 + TWO) & mask;
    assign bus.pixel_addr6 = (base_q + W2) & mask;
    assign bus.pixel_addr7 = (base_q + W2 + ONE) & mask;
    assign bus.pixel_addr8 = (base_q + W2 + TWO) & mask;
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler on a 5x5 image: latch model,
// scoreboard queue of hand-computed patches and a negedge monitor.
module tb_conv_window_scheduler;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int ADDR_W = 10;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
        logic       lfp;
        logic [9:0] base;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_window_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

    conv_window_scheduler #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // hand-computed 5x5 scan order
    int tb_row  [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int tb_col  [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int tb_base [9] = '{0, 5, 10, 1, 6, 11, 2, 7, 12};
    int tb_lfp  [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
    int offs    [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   lat      = 1;
    bit   fresh    = 1'b0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [89:0] dut_addrs();
        return {bus.pixel_addr0, bus.pixel_addr1, bus.pixel_addr2,
                bus.pixel_addr3, bus.pixel_addr4, bus.pixel_addr5,
                bus.pixel_addr6, bus.pixel_addr7, bus.pixel_addr8};
    endfunction

    function automatic logic [89:0] exp_addrs(input logic [9:0] base);
        logic [89:0] r;
        r = '0;
        for (int n = 0; n < 9; n++)
            r[(8 - n) * 10 +: 10] = base + 10'(offs[n]);
        return r;
    endfunction

    function automatic logic [127:0] outs_vec();
        return 128'({bus.load, bus.load_full_patch, bus.patch_valid,
                     bus.busy, bus.scan_done, bus.out_row, bus.out_col,
                     dut_addrs()});
    endfunction

    task automatic push_scan(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.row  = 10'(tb_row[k]);
            e.col  = 10'(tb_col[k]);
            e.lfp  = 1'(tb_lfp[k]);
            e.base = 10'(tb_base[k]);
            exp_q.push_back(e);
        end
    endtask

    // patch latch: leaves load_done stale through the ISSUE cycle,
    // clears it one cycle later, then raises it after lat cycles
    initial begin : latch_model
        int phase;
        int cnt;
        phase = 0;
        cnt = 0;
        bus.load_done = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || !bus.load) begin
                phase = 0;
            end else if (phase == 0) begin
                fresh = 1'b0;
                phase = 1;
            end else if (phase == 1) begin
                bus.load_done = 1'b0;
                cnt = lat;
                phase = 2;
            end else if (phase == 2) begin
                if (cnt == 0) begin
                    bus.load_done = 1'b1;
                    fresh = 1'b1;
                    phase = 3;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // monitor: pops an expectation per presented patch, checks it every
    // cycle the patch is held
    initial begin : monitor
        exp_t cur;
        bit   have;
        logic lfp_seen;
        have = 1'b0;
        lfp_seen = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                have = 1'b0;
            end else begin
                if (bus.load) lfp_seen = bus.load_full_patch;
                if (bus.scan_done) done_cnt++;
                if (bus.patch_valid) begin
                    if (!have) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_patch: row %0d col %0d",
                                     bus.out_row, bus.out_col);
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        have = 1'b1;
                        check("fresh_load_done", 128'(fresh), 128'(1));
                        check("load_full_patch", 128'(lfp_seen),
                              128'(cur.lfp));
                    end
                    check("busy_present", 128'(bus.busy), 128'(1));
                    check("out_row", 128'(bus.out_row), 128'(cur.row));
                    check("out_col", 128'(bus.out_col), 128'(cur.col));
                    check("pixel_addrs", 128'(dut_addrs()),
                          128'(exp_addrs(cur.base)));
                end else begin
                    have = 1'b0;
                end
            end
        end
    end

    task automatic wait_pv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.patch_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL patch_valid_timeout: got 0 expected 1");
    endtask

    task automatic serve(input int hold, input bit pulse_start,
                         input bit start_with_ready);
        bit ok;
        wait_pv(ok);
        if (!ok) return;
        for (int i = 0; i < hold; i++) begin
            if (pulse_start && i == 4) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        if (start_with_ready) bus.start = 1'b1;
        bus.patch_ready = 1'b1;
        @(negedge clk);
        bus.patch_ready = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin : stimulus
        bit seen;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.patch_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_vec(), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 128'(bus.busy), 128'(0));

        // full scan with a long hold, stray start pulses and mixed latency
        lat = 1;
        done_cnt = 0;
        push_scan(9);
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            lat = k % 3;
            serve((k == 1) ? 10 : (k % 3), k == 1, k == 3);
        end
        repeat (4) @(negedge clk);
        check("scan1_done_pulses", 128'(done_cnt), 128'(1));
        check("scan1_busy_end", 128'(bus.busy), 128'(0));
        check("scan1_queue_empty", 128'(exp_q.size()), 128'(0));

        // scan interrupted by reset while waiting on patch 5
        lat = 4;
        push_scan(4);
        pulse_start();
        for (int k = 0; k < 4; k++) serve(1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.load) seen = 1'b1;
            else @(negedge clk);
        end
        check("patch5_load_seen", 128'(seen), 128'(1));
        repeat (2) @(negedge clk);
        check("patch5_in_wait",
              128'({bus.load, bus.patch_valid, bus.busy}), 128'(3'b101));
        rst = 1'b0;
        #1;
        check("midscan_reset", outs_vec(), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("no_resume", 128'({bus.busy, bus.load}), 128'(0));
        check("scan2_queue_empty", 128'(exp_q.size()), 128'(0));

        // fresh scan after reset starts at row 0, col 0 with a full load
        lat = 0;
        done_cnt = 0;
        push_scan(9);
        pulse_start();
        for (int k = 0; k < 9; k++) serve(0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("scan3_done_pulses", 128'(done_cnt), 128'(1));
        check("scan3_busy_end", 128'(bus.busy), 128'(0));
        check("scan3_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
